// File: rtl/sd_dev_cmd_phy.sv
// rtl/sd_dev_cmd_phy.sv - SD card-side CMD line PHY: CRC7-checked command receive, 48/136-bit response serialiser
module sd_dev_cmd_phy #(
  parameter int NCR = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cmd_in,
  output logic         o_cmd_out,
  output logic         o_cmd_dir,
  output logic         o_cmd_stb,
  output logic [5:0]   o_cmd_index,
  output logic [31:0]  o_cmd_arg,
  output logic         o_crc_err,
  input  logic         i_rsp_stb,
  input  logic [1:0]   i_rsp_type,
  input  logic [5:0]   i_rsp_index,
  input  logic [127:0] i_rsp_data,
  output logic         o_busy,
  output logic         o_rsp_done
);
  typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT_RSP, S_NCR_WAIT, S_TX} state_t;

  localparam logic [6:0] NCR_LOAD = 7'(NCR - 1);

  state_t       state_q, state_d;
  logic [7:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]   ncr_cnt_q, ncr_cnt_d;
  logic [6:0]   crc_q, crc_d;
  logic [44:0]  rx_sr_q, rx_sr_d;
  logic [127:0] tx_sr_q, tx_sr_d;
  logic         rsp_long_q, rsp_long_d;
  logic         rsp_r3_q, rsp_r3_d;
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  arg_q, arg_d;
  logic         cmd_out_q, cmd_out_d;
  logic         cmd_dir_q, cmd_dir_d;
  logic         cmd_stb_q, cmd_stb_d;
  logic         crc_err_q, crc_err_d;
  logic         rsp_done_q, rsp_done_d;

  logic [7:0]   tx_pos, tx_len, tx_crc_lo, tx_crc_start;
  logic         tx_bit;
  logic [6:0]   crc_tx_next;
  logic [127:0] tx_shift;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    return {crc[5:0], 1'b0} ^ ((crc[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  // Next response bit: payload, then the accumulated (or forced) CRC field, then the end bit.
  always_comb begin
    tx_pos       = (state_q == S_TX) ? bit_cnt_q : 8'd0;
    tx_len       = rsp_long_q ? 8'd136 : 8'd48;
    tx_crc_lo    = rsp_long_q ? 8'd8 : 8'd0;
    tx_crc_start = rsp_long_q ? 8'd128 : 8'd40;
    tx_bit       = 1'b1;
    crc_tx_next  = crc_q;
    tx_shift     = tx_sr_q;
    if (tx_pos < tx_crc_start) begin
      tx_bit   = tx_sr_q[127];
      tx_shift = {tx_sr_q[126:0], 1'b0};
      if (tx_pos >= tx_crc_lo) crc_tx_next = crc7_step(crc_q, tx_sr_q[127]);
    end else if (tx_pos < tx_crc_start + 8'd7) begin
      tx_bit      = rsp_r3_q | crc_q[6];
      crc_tx_next = {crc_q[5:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ncr_cnt_d  = ncr_cnt_q;
    crc_d      = crc_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    rsp_long_d = rsp_long_q;
    rsp_r3_d   = rsp_r3_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    cmd_out_d  = cmd_out_q;
    cmd_dir_d  = cmd_dir_q;
    cmd_stb_d  = 1'b0;
    crc_err_d  = 1'b0;
    rsp_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_cmd_in) begin
          state_d   = S_RX;
          bit_cnt_d = 8'd1;
          crc_d     = 7'd0;
        end
      end
      S_RX: begin
        rx_sr_d   = {rx_sr_q[43:0], i_cmd_in};
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q <= 8'd39) crc_d = crc7_step(crc_q, i_cmd_in);
        if (bit_cnt_q == 8'd1 && !i_cmd_in) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == 8'd47) begin
          // rx_sr_q now holds bits 2..46; the live input is the end bit.
          if (crc_q == rx_sr_q[6:0] && i_cmd_in) begin
            idx_d     = rx_sr_q[44:39];
            arg_d     = rx_sr_q[38:7];
            cmd_stb_d = 1'b1;
            state_d   = S_WAIT_RSP;
          end else begin
            crc_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_WAIT_RSP: begin
        if (i_rsp_stb) begin
          if (i_rsp_type == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_NCR_WAIT;
            ncr_cnt_d  = NCR_LOAD;
            crc_d      = 7'd0;
            rsp_long_d = (i_rsp_type == 2'd3);
            rsp_r3_d   = (i_rsp_type == 2'd2);
            tx_sr_d    = (i_rsp_type == 2'd3) ? {2'b00, 6'h3F, i_rsp_data[127:8]}
                                              : {2'b00, i_rsp_index, i_rsp_data[31:0], 88'd0};
          end
        end else if (!i_cmd_in) begin
          state_d   = S_RX;
          bit_cnt_d = 8'd1;
          crc_d     = 7'd0;
        end
      end
      S_NCR_WAIT: begin
        if (ncr_cnt_q == 7'd0) begin
          state_d   = S_TX;
          cmd_dir_d = 1'b1;
          cmd_out_d = tx_bit;
          tx_sr_d   = tx_shift;
          crc_d     = crc_tx_next;
          bit_cnt_d = 8'd1;
        end else begin
          ncr_cnt_d = ncr_cnt_q - 7'd1;
        end
      end
      S_TX: begin
        if (bit_cnt_q == tx_len) begin
          state_d    = S_IDLE;
          cmd_dir_d  = 1'b0;
          cmd_out_d  = 1'b1;
          rsp_done_d = 1'b1;
        end else begin
          cmd_out_d = tx_bit;
          tx_sr_d   = tx_shift;
          crc_d     = crc_tx_next;
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 8'd0;
      ncr_cnt_q  <= 7'd0;
      crc_q      <= 7'd0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rsp_long_q <= 1'b0;
      rsp_r3_q   <= 1'b0;
      idx_q      <= 6'd0;
      arg_q      <= 32'd0;
      cmd_out_q  <= 1'b1;
      cmd_dir_q  <= 1'b0;
      cmd_stb_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      rsp_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ncr_cnt_q  <= ncr_cnt_d;
      crc_q      <= crc_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      rsp_long_q <= rsp_long_d;
      rsp_r3_q   <= rsp_r3_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      cmd_out_q  <= cmd_out_d;
      cmd_dir_q  <= cmd_dir_d;
      cmd_stb_q  <= cmd_stb_d;
      crc_err_q  <= crc_err_d;
      rsp_done_q <= rsp_done_d;
    end
  end

  assign o_cmd_out   = cmd_out_q;
  assign o_cmd_dir   = cmd_dir_q;
  assign o_cmd_stb   = cmd_stb_q;
  assign o_cmd_index = idx_q;
  assign o_cmd_arg   = arg_q;
  assign o_crc_err   = crc_err_q;
  assign o_rsp_done  = rsp_done_q;
  assign o_busy      = !(state_q == S_IDLE || state_q == S_WAIT_RSP);
endmodule

// File: tb/tb_sd_dev_cmd_phy.sv
// tb/tb_sd_dev_cmd_phy.sv - vector table, corner sequences and random traffic against a frame-level model
module tb_sd_dev_cmd_phy;
  localparam int NCR = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cmd_in;
  logic         o_cmd_out, o_cmd_dir, o_cmd_stb, o_crc_err, o_busy, o_rsp_done;
  logic [5:0]   o_cmd_index;
  logic [31:0]  o_cmd_arg;
  logic         i_rsp_stb;
  logic [1:0]   i_rsp_type;
  logic [5:0]   i_rsp_index;
  logic [127:0] i_rsp_data;

  always #5 clk = ~clk;

  sd_dev_cmd_phy #(.NCR(NCR)) dut (
    .clk(clk), .rst(rst), .i_cmd_in(i_cmd_in), .o_cmd_out(o_cmd_out), .o_cmd_dir(o_cmd_dir),
    .o_cmd_stb(o_cmd_stb), .o_cmd_index(o_cmd_index), .o_cmd_arg(o_cmd_arg), .o_crc_err(o_crc_err),
    .i_rsp_stb(i_rsp_stb), .i_rsp_type(i_rsp_type), .i_rsp_index(i_rsp_index), .i_rsp_data(i_rsp_data),
    .o_busy(o_busy), .o_rsp_done(o_rsp_done)
  );

  typedef struct {
    logic [47:0] tok;
    logic        exp_stb;
    logic        exp_err;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC7 over frame positions [lo,hi), position 0 being v[135].
  function automatic logic [6:0] crc7(input logic [135:0] v, input int lo, input int hi);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int p = lo; p < hi; p++) begin
      fb = c[6] ^ v[135-p];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] v;
    v = '0;
    v[135:96] = {2'b01, idx, arg};
    return {2'b01, idx, arg, crc7(v, 0, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk_rsp(input logic [1:0] t, input logic [5:0] idx, input logic [127:0] d);
    logic [135:0] v;
    v = '0;
    if (t == 2'd3) begin
      v[135:8] = {2'b00, 6'h3F, d[127:8]};
      v[7:1]   = crc7(v, 8, 128);
      v[0]     = 1'b1;
    end else begin
      v[135:96] = {2'b00, idx, d[31:0]};
      v[95:89]  = (t == 2'd2) ? 7'h7F : crc7(v, 0, 40);
      v[88]     = 1'b1;
    end
    return v;
  endfunction

  task automatic apply_cmd(input string name, input logic [47:0] tok, input logic exp_stb,
                           input logic exp_err, input logic [5:0] exp_idx, input logic [31:0] exp_arg);
    logic early;
    early = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      i_cmd_in = tok[i];
      tick();
      if (i > 0 && (o_cmd_stb || o_crc_err)) early = 1'b1;
    end
    i_cmd_in = 1'b1;
    check1($sformatf("%s early pulse", name), early, 1'b0);
    check1($sformatf("%s stb", name), o_cmd_stb, exp_stb);
    check1($sformatf("%s crc_err", name), o_crc_err, exp_err);
    check_w($sformatf("%s index/arg", name), 136'({o_cmd_index, o_cmd_arg}), 136'({exp_idx, exp_arg}));
    tick();
    check1($sformatf("%s pulse width", name), o_cmd_stb | o_crc_err, 1'b0);
  endtask

  task automatic do_rsp(input string name, input logic [1:0] t, input logic [5:0] idx,
                        input logic [127:0] d, input logic start_too, output logic [135:0] cap);
    int   lat, n, act;
    logic busy_ok;
    cap = '0;
    i_rsp_stb = 1'b1; i_rsp_type = t; i_rsp_index = idx; i_rsp_data = d;
    if (start_too) i_cmd_in = 1'b0;
    tick();
    i_rsp_stb = 1'b0; i_cmd_in = 1'b1;
    i_rsp_type = 2'($urandom); i_rsp_index = 6'($urandom);
    i_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    if (t == 2'd0) begin
      act = 0;
      for (int k = 0; k < NCR + 4; k++) begin
        if (o_cmd_dir || o_rsp_done || o_busy) act++;
        tick();
      end
      check_i($sformatf("%s no line activity", name), act, 0);
      return;
    end
    lat = 0; busy_ok = 1'b1;
    while (!o_cmd_dir && lat < 100) begin
      if (!o_busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check_i($sformatf("%s start latency", name), lat, NCR);
    n = 0;
    while (o_cmd_dir && n < 140) begin
      if (!o_busy) busy_ok = 1'b0;
      if (n < 136) cap[135-n] = o_cmd_out;
      n++;
      tick();
    end
    check_i($sformatf("%s driven cycles", name), n, (t == 2'd3) ? 136 : 48);
    check_w($sformatf("%s frame", name), cap, mk_rsp(t, idx, d));
    check_w($sformatf("%s release dir/out/done/busy", name),
            136'({o_cmd_dir, o_cmd_out, o_rsp_done, o_busy}), 136'(4'b0110));
    check1($sformatf("%s busy while active", name), busy_ok, 1'b1);
    tick();
    check1($sformatf("%s done width", name), o_rsp_done, 1'b0);
  endtask

  initial begin
    vec_t         vecs[6];
    logic [47:0]  tok, ref_tok;
    logic [135:0] cap;
    logic         good, flag;
    logic [1:0]   rt;
    logic [127:0] rd;
    int           act;

    rst = 1'b0; i_cmd_in = 1'b1; i_rsp_stb = 1'b0; i_rsp_type = 2'd0;
    i_rsp_index = 6'd0; i_rsp_data = '0;
    m_idx = 6'd0; m_arg = 32'd0;

    vecs[0] = '{48'h40_0000_0000_95, 1'b1, 1'b0, 6'd0, 32'h0000_0000};
    vecs[1] = '{48'h48_0000_01AA_87, 1'b1, 1'b0, 6'd8, 32'h0000_01AA};
    vecs[2] = '{48'h48_0000_01AA_86, 1'b0, 1'b1, 6'd8, 32'h0000_01AA};
    vecs[3] = '{48'h48_0000_01AA_85, 1'b0, 1'b1, 6'd8, 32'h0000_01AA};
    vecs[4] = '{mk_cmd(6'd17, 32'h1234_5678), 1'b1, 1'b0, 6'd17, 32'h1234_5678};
    vecs[5] = '{mk_cmd(6'd55, 32'hFFFF_0000) ^ 48'h0000_0001_0000, 1'b0, 1'b1, 6'd17, 32'h1234_5678};

    #12;
    check_w("reset outputs", 136'({o_cmd_dir, o_cmd_out, o_cmd_stb, o_crc_err, o_rsp_done, o_busy, o_cmd_index, o_cmd_arg}),
            136'({6'b010000, 6'd0, 32'd0}));
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();

    for (int v = 0; v < 6; v++) begin
      apply_cmd($sformatf("vec%0d", v), vecs[v].tok, vecs[v].exp_stb, vecs[v].exp_err, vecs[v].exp_idx, vecs[v].exp_arg);
      tick();
    end
    m_idx = 6'd17; m_arg = 32'h1234_5678;

    // Strobe in IDLE must not start a response.
    i_rsp_stb = 1'b1; i_rsp_type = 2'd1;
    tick();
    i_rsp_stb = 1'b0;
    act = 0;
    for (int k = 0; k < NCR + 4; k++) begin
      if (o_cmd_dir || o_busy) act++;
      tick();
    end
    check_i("strobe outside WAIT_RSP ignored", act, 0);

    apply_cmd("cmd8", 48'h48_0000_01AA_87, 1'b1, 1'b0, 6'd8, 32'h1AA);
    do_rsp("r7", 2'd1, 6'd8, 128'h1AA, 1'b0, cap);
    check_w("r7 literal token", 136'(cap[135:88]), 136'(48'h08_0000_01AA_13));

    apply_cmd("cmd2", mk_cmd(6'd2, 32'd0), 1'b1, 1'b0, 6'd2, 32'd0);
    do_rsp("r2 zero", 2'd3, 6'd0, 128'd0, 1'b0, cap);
    apply_cmd("acmd41", mk_cmd(6'd41, 32'h40FF_8000), 1'b1, 1'b0, 6'd41, 32'h40FF_8000);
    do_rsp("r3", 2'd2, 6'h3F, 128'h00FF_8000, 1'b0, cap);
    check_w("r3 crc field", 136'(cap[95:88]), 136'(8'hFF));
    apply_cmd("cmd13", mk_cmd(6'd13, 32'h0001_0000), 1'b1, 1'b0, 6'd13, 32'h0001_0000);
    do_rsp("rsp beats start bit", 2'd1, 6'd13, 128'h900, 1'b1, cap);
    apply_cmd("cmd7", mk_cmd(6'd7, 32'h0001_0000), 1'b1, 1'b0, 6'd7, 32'h0001_0000);
    do_rsp("type0", 2'd0, 6'd7, 128'd0, 1'b0, cap);
    m_idx = 6'd7; m_arg = 32'h0001_0000;

    for (int it = 0; it < 24; it++) begin
      tok = mk_cmd(6'($urandom), $urandom);
      if ($urandom_range(3) == 0) tok = tok ^ (48'h1 << $urandom_range(45, 0));
      ref_tok = mk_cmd(tok[45:40], tok[39:8]);
      good = (tok == ref_tok);
      if (good) begin m_idx = tok[45:40]; m_arg = tok[39:8]; end
      apply_cmd($sformatf("rnd%0d cmd", it), tok, good, !good, m_idx, m_arg);
      if (good && $urandom_range(4) != 0) begin
        rt = 2'($urandom);
        rd = {$urandom, $urandom, $urandom, $urandom};
        do_rsp($sformatf("rnd%0d rsp", it), rt, 6'($urandom), rd, 1'b0, cap);
      end
      repeat ($urandom_range(3)) tick();
    end

    // Another device's response on the line: framer drops it at the transmission bit.
    tok = 48'h08_0000_01AA_13;
    flag = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      i_cmd_in = tok[i];
      tick();
      if (i == 46) check1("foreign token back to IDLE", o_busy, 1'b0);
      if (o_cmd_stb || o_crc_err) flag = 1'b1;
    end
    i_cmd_in = 1'b1;
    tick();
    if (o_cmd_stb || o_crc_err) flag = 1'b1;
    check1("foreign token silent", flag, 1'b0);
    check_w("foreign token keeps index/arg", 136'({o_cmd_index, o_cmd_arg}), 136'({m_idx, m_arg}));
    #2 rst = 1'b0;
    #4 rst = 1'b1;
    tick();

    // Reset in the middle of a response releases the line without a clock edge.
    apply_cmd("cmd8 pre-reset", 48'h48_0000_01AA_87, 1'b1, 1'b0, 6'd8, 32'h1AA);
    i_rsp_stb = 1'b1; i_rsp_type = 2'd1; i_rsp_index = 6'd8; i_rsp_data = 128'h1AA;
    tick();
    i_rsp_stb = 1'b0;
    act = 0;
    while (!o_cmd_dir && act < 100) begin tick(); act++; end
    check_i("pre-reset start latency", act, NCR);
    repeat (20) tick();
    check1("driving bit 20", o_cmd_dir, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_w("async reset mid-TX", 136'({o_cmd_dir, o_cmd_out, o_busy, o_cmd_index, o_cmd_arg}),
            136'({3'b010, 6'd0, 32'd0}));
    #2 rst = 1'b1;
    tick();
    apply_cmd("cmd0 after reset", 48'h40_0000_0000_95, 1'b1, 1'b0, 6'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_dev_cmd_phy.md
Name: sd_dev_cmd_phy

Overview:
- Card-side (device) endpoint of the SD CMD line, the counterpart of the host platform PHY.
- Clocked by the SD clock the host drives; samples host command tokens on the CMD line and checks their CRC7, then presents them to the card logic.
- Serialises R1/R3/R7-style 48-bit or R2-style 136-bit responses back onto the CMD line through a tristate-control output pair.
- Used in cocotb benches as the card model PHY, and as the PHY for an SD device core.

Parameters:
- NCR, 2: SD clocks between the response request and the response start bit; legal range 2..64.

Ports:
- clk  input  1  SD clock from the host; all logic is on the rising edge.
- rst  input  1  Reset; asynchronous, active-low.
- i_cmd_in  input  1  Sampled CMD line; idles high through the pull-up.
- o_cmd_out  output  1  Value driven on CMD when o_cmd_dir=1.
- o_cmd_dir  output  1  1 = device drives CMD, 0 = released.
- o_cmd_stb  output  1  One-cycle pulse when a valid command is received.
- o_cmd_index  output  6  Index of the last received command.
- o_cmd_arg  output  32  Argument of the last received command.
- o_crc_err  output  1  One-cycle pulse when a framed command fails CRC7 or the end-bit check.
- i_rsp_stb  input  1  Response request; honoured only in WAIT_RSP.
- i_rsp_type  input  2  0 = no response, 1 = short, 2 = short with CRC field forced to 7'h7F (R3), 3 = long (R2).
- i_rsp_index  input  6  Index field for short responses.
- i_rsp_data  input  128  Short response uses [31:0]; long response uses [127:8].
- o_busy  output  1  High in every state except IDLE and WAIT_RSP.
- o_rsp_done  output  1  One-cycle pulse when the line is released after the end bit.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; o_cmd_dir=0, o_cmd_out=1, o_cmd_stb=0, o_crc_err=0, o_rsp_done=0, o_busy=0, o_cmd_index=0, o_cmd_arg=0.
- Reset asserted mid-transmission releases CMD immediately, without waiting for a clock edge.
- CRC7: polynomial x^7+x^3+1, init 0, bit-serial, MSB first.
  - fb = crc[6]^bit; crc_next = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
- IDLE: i_cmd_in=0 is the start bit; go to RX, bit counter=1, CRC cleared.
- RX: shift in bits 1..47.
  - Bit 1 (transmission bit) = 0 means the token is another device's response: return to IDLE silently, no pulses.
  - CRC accumulates over bits 0..39. Bits 40..46 are the received CRC; bit 47 is the end bit.
- Cycle after bit 47 is sampled:
  - CRC match and end bit = 1: latch index/arg, pulse o_cmd_stb, go to WAIT_RSP.
  - Otherwise: pulse o_crc_err, leave index/arg unchanged, go to IDLE.
- WAIT_RSP:
  - i_rsp_stb with type 0: go to IDLE, no line activity, no o_rsp_done.
  - i_rsp_stb with type 1..3: latch type/index/data, go to NCR_WAIT.
  - i_cmd_in=0 with i_rsp_stb=0: new command; the pending response is discarded and the block enters RX as from IDLE.
  - i_rsp_stb and start bit in the same cycle: the response wins.
  - i_rsp_stb outside WAIT_RSP is ignored.
- NCR_WAIT: line released. If i_rsp_stb is sampled at edge T, o_cmd_dir rises at edge T+NCR with o_cmd_out=0 (start bit).
- TX, one bit per clock:
  - Short response (48 bits): 0, 0, i_rsp_index, data[31:0], CRC7 over the first 40 bits (7'h7F for type 2), 1.
  - Long response (136 bits): 0, 0, 6'h3F, data[127:8], CRC7 over data[127:8] only, 1.
  - o_cmd_dir is high for exactly 48 or 136 consecutive cycles.
- End of TX: on the edge after the end-bit cycle, o_cmd_dir=0, o_cmd_out=1, o_rsp_done pulses, state goes to IDLE.
- No command is received while driving (TX) or during NCR_WAIT; the CMD line is ignored in those states.

Test Plan:
- CMD0 token 0x40_00000000_95 -> o_cmd_stb one cycle after the end bit; index=0, arg=0x00000000; o_crc_err stays 0.
- CMD8 token 0x48_000001AA_87 -> index=8, arg=0x000001AA. Same token with the CRC byte 0x86 -> o_crc_err pulse, no o_cmd_stb, index/arg keep their previous values.
- Token with transmission bit 0 (0x08_000001AA_13) -> no o_cmd_stb, no o_crc_err; state back to IDLE.
- After CMD8: i_rsp_stb, type=1, index=8, data[31:0]=0x1AA -> CMD drives 0x08_000001AA_13 starting exactly NCR=2 cycles after the strobe, 48 driven cycles, then o_rsp_done.
- Type=3 with data[127:8]=120'h0 -> 136 driven cycles: 0, 0, 6'h3F, 120 zeros, CRC 7'h00, end 1. Type=2 -> CRC field 7'h7F.
- Assert rst mid-TX (bit 20) -> o_cmd_dir falls asynchronously. After release, CMD0 is received normally.
